ahb_lite_master_bridge: RTL

- Sits directly downstream of the multicycle ARM core's memory port (MemWrite/Adr/WriteData/ReadData).
- Converts each core request into one single-beat AHB-Lite transfer and stalls the core until the data phase completes.
- Returns read data plus a done/error strobe to the core controller.
- Single AHB-Lite master: no arbitration, no bursts, word-size transfers only.

---
 rtl/ahb_lite_master_bridge.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge: turns one core memory request into one single-beat,
// word-size AHB-Lite transfer. The core is stalled via Busy until the data
// phase finishes; completion is reported with a one-cycle Done (and Err) pulse.
module ahb_lite_master_bridge #(
    parameter int WAIT_W     = 8,
    parameter bit ALIGN_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    // core side
    input  logic              Req,
    input  logic              MemWrite,
    input  logic [31:0]       Adr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [WAIT_W-1:0] Waits,
    // AHB-Lite master side
    output logic [31:0]       HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;

    logic [31:0]         haddr_d, hwdata_d, rdata_d;
    logic [1:0]          htrans_d;
    logic                hwrite_d, busy_d, done_d, err_d;
    logic [WAIT_W-1:0]   waits_d;
    logic [31:0]         adr_eff;

    // Only word transfers, only single bursts.
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b000;

    // Word alignment of the outgoing address is a build-time choice.
    assign adr_eff = ALIGN_ADDR ? {Adr[31:2], 2'b00} : Adr;

    // Register every output and the FSM state; reset abandons any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wdata_q  <= '0;
            wcnt_q   <= '0;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HTRANS   <= TRANS_IDLE;
            HWDATA   <= '0;
            ReadData <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
            Waits    <= '0;
        end else begin
            state_q  <= state_d;
            wdata_q  <= wdata_d;
            wcnt_q   <= wcnt_d;
            HADDR    <= haddr_d;
            HWRITE   <= hwrite_d;
            HTRANS   <= htrans_d;
            HWDATA   <= hwdata_d;
            ReadData <= rdata_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Err      <= err_d;
            Waits    <= waits_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a phase moves on.
    always_comb begin
        state_d  = state_q;
        wdata_d  = wdata_q;
        wcnt_d   = wcnt_q;
        haddr_d  = HADDR;
        hwrite_d = HWRITE;
        htrans_d = HTRANS;
        hwdata_d = HWDATA;
        rdata_d  = ReadData;
        busy_d   = Busy;
        done_d   = 1'b0;
        err_d    = 1'b0;
        waits_d  = Waits;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    hwrite_d = MemWrite;
                    haddr_d  = adr_eff;
                    wdata_d  = WriteData;
                    htrans_d = TRANS_NONSEQ;
                    busy_d   = 1'b1;
                    state_d  = S_ADDR;
                end
            end

            S_ADDR: begin
                // Address phase stays frozen on the bus until the slave takes it.
                if (HREADY) begin
                    htrans_d = TRANS_IDLE;
                    if (HWRITE) hwdata_d = wdata_q;
                    wcnt_d   = '0;
                    state_d  = S_DATA;
                end
            end

            S_DATA: begin
                if (!HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERR2;
                    end else if (wcnt_q != {WAIT_W{1'b1}}) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    // A single-cycle ERROR is illegal AHB, but still report it as an error.
                    done_d  = 1'b1;
                    waits_d = wcnt_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (HRESP)        err_d   = 1'b1;
                    else if (!HWRITE) rdata_d = HRDATA;
                end
            end

            S_ERR2: begin
                // Second ERROR cycle; a low HREADY here is a slave violation, keep waiting.
                if (HREADY) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    waits_d = wcnt_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
